// File: rtl/add_operand_loader.sv
// Byte-serial operand loader for a 16-bit adder: gathers a, b, cin from an 8-bit stream,
// holds them stable for a settle window, then captures the 17-bit sum onto a valid/ready port.
module add_operand_loader #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  input  logic        in_cin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [16:0] add_sum,
  output logic [16:0] res_sum,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_OUT} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    r_byte_cnt;
  logic [7:0]    r_a_lo;
  logic [7:0]    r_a_hi;
  logic [7:0]    r_b_lo;
  logic [CW-1:0] r_settle_cnt;
  logic [15:0]   r_add_a;
  logic [15:0]   r_add_b;
  logic          r_add_cin;
  logic [16:0]   r_res_sum;
  logic          r_res_valid;
  logic          w_accept;
  logic          w_last;
  logic          w_settle_done;

  assign in_ready      = rst_n & (r_state == S_LOAD);
  assign w_accept      = in_valid & in_ready;
  // A start-of-frame byte always restarts the frame, so it can never complete one.
  assign w_last        = w_accept & ~in_sof & (r_byte_cnt == 2'd3);
  assign w_settle_done = (r_state == S_SETTLE) && (r_settle_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD:   if (w_last) w_state_next = S_SETTLE;
      S_SETTLE: if (w_settle_done) w_state_next = S_OUT;
      S_OUT:    if (r_res_valid && res_ready) w_state_next = S_LOAD;
      default:  w_state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_byte_cnt   <= 2'd0;
      r_a_lo       <= 8'd0;
      r_a_hi       <= 8'd0;
      r_b_lo       <= 8'd0;
      r_settle_cnt <= '0;
      r_add_a      <= 16'd0;
      r_add_b      <= 16'd0;
      r_add_cin    <= 1'b0;
      r_res_sum    <= 17'd0;
      r_res_valid  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (in_sof) begin
          r_a_lo     <= in_data;
          r_byte_cnt <= 2'd1;
        end else begin
          case (r_byte_cnt)
            2'd0: begin r_a_lo <= in_data; r_byte_cnt <= 2'd1; end
            2'd1: begin r_a_hi <= in_data; r_byte_cnt <= 2'd2; end
            2'd2: begin r_b_lo <= in_data; r_byte_cnt <= 2'd3; end
            default: begin
              // Adder inputs change only here, all together, keeping them glitch-free.
              r_add_a      <= {r_a_hi, r_a_lo};
              r_add_b      <= {in_data, r_b_lo};
              r_add_cin    <= in_cin;
              r_byte_cnt   <= 2'd0;
              r_settle_cnt <= CW'(SETTLE_CYCLES - 1);
            end
          endcase
        end
      end
      if (r_state == S_SETTLE) begin
        if (w_settle_done) begin
          r_res_sum   <= add_sum;
          r_res_valid <= 1'b1;
        end else begin
          r_settle_cnt <= r_settle_cnt - 1'b1;
        end
      end
      if ((r_state == S_OUT) && r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_cin   = r_add_cin;
  assign res_sum   = r_res_sum;
  assign res_valid = r_res_valid;
  assign busy      = (r_state == S_SETTLE) || (r_state == S_OUT);

endmodule

// File: tb/tb_add_operand_loader.sv
// Directed bench for add_operand_loader: one instance with a 1-clock settle window and one
// with a 3-clock window, selected through a shared set of stimulus/observation signals.
module tb_add_operand_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sel;
  logic [7:0] in_data;
  logic       in_sof;
  logic       in_cin;
  logic       in_valid;
  logic       res_ready;

  int checks = 0;
  int errors = 0;

  logic        in_ready_1, add_cin_1, res_valid_1, busy_1;
  logic [15:0] add_a_1, add_b_1;
  logic [16:0] add_sum_1, res_sum_1;
  logic        in_ready_3, add_cin_3, res_valid_3, busy_3;
  logic [15:0] add_a_3, add_b_3;
  logic [16:0] add_sum_3, res_sum_3;

  // Behavioural stand-in for the carry-select adder.
  assign add_sum_1 = {1'b0, add_a_1} + {1'b0, add_b_1} + {16'd0, add_cin_1};
  assign add_sum_3 = {1'b0, add_a_3} + {1'b0, add_b_3} + {16'd0, add_cin_3};

  add_operand_loader #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sof(in_sof), .in_cin(in_cin),
    .in_valid(in_valid & ~sel), .in_ready(in_ready_1), .add_a(add_a_1), .add_b(add_b_1),
    .add_cin(add_cin_1), .add_sum(add_sum_1), .res_sum(res_sum_1), .res_valid(res_valid_1),
    .res_ready(res_ready & ~sel), .busy(busy_1)
  );

  add_operand_loader #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sof(in_sof), .in_cin(in_cin),
    .in_valid(in_valid & sel), .in_ready(in_ready_3), .add_a(add_a_3), .add_b(add_b_3),
    .add_cin(add_cin_3), .add_sum(add_sum_3), .res_sum(res_sum_3), .res_valid(res_valid_3),
    .res_ready(res_ready & sel), .busy(busy_3)
  );

  wire        in_ready  = sel ? in_ready_3  : in_ready_1;
  wire [15:0] add_a     = sel ? add_a_3     : add_a_1;
  wire [15:0] add_b     = sel ? add_b_3     : add_b_1;
  wire        add_cin   = sel ? add_cin_3   : add_cin_1;
  wire [16:0] res_sum   = sel ? res_sum_3   : res_sum_1;
  wire        res_valid = sel ? res_valid_3 : res_valid_1;
  wire        busy      = sel ? busy_3      : busy_1;

  task automatic send_byte(input logic [7:0] d, input logic sof, input logic c, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_data = d; in_sof = sof; in_cin = c; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL byte_accept_timeout got in_ready=%0b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0; in_cin = 1'b0;
  endtask

  task automatic send_txn(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic sof0, input int gap);
    send_byte(a[7:0],  sof0, 1'b0, gap);
    send_byte(a[15:8], 1'b0, 1'b0, gap);
    send_byte(b[7:0],  1'b0, 1'b0, gap);
    send_byte(b[15:8], 1'b0, c,    gap);
  endtask

  // Returns the number of rising edges from the byte3 accept edge to res_valid.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!res_valid && lat < 50);
    if (!res_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout got res_valid=%0b want 1", res_valid);
    end
  endtask

  task automatic finish_result(input string name);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_handshake got res_valid=%0b in_ready=%0b want 0/1", name, res_valid, in_ready);
    end
  endtask

  task automatic check_sum(input string name, input logic [16:0] exp, input int lat, input int exp_lat);
    checks++;
    if (res_sum !== exp) begin
      errors++;
      $display("FAIL %s_sum got %05h want %05h", name, res_sum, exp);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat);
    end
    $display("txn %s sum=%05h latency=%0d", name, res_sum, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    in_sof = 1'b0; in_cin = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if (in_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || add_a !== 16'd0 ||
          add_b !== 16'd0 || add_cin !== 1'b0 || res_sum !== 17'd0) begin
        errors++;
        $display("FAIL reset_state sel=%0d got rdy=%0b vld=%0b busy=%0b a=%04h b=%04h c=%0b s=%05h want all 0",
                 s, in_ready, res_valid, busy, add_a, add_b, add_cin, res_sum);
      end
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %0b want 1", in_ready);
    end
  endtask

  task automatic test_carry_out();
    int lat;
    sel = 1'b0;
    send_txn(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    wait_result(lat);
    check_sum("carry_out", 17'h10000, lat, 1);
    finish_result("carry_out");
    send_txn(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 0);
    wait_result(lat);
    check_sum("max", 17'h1FFFF, lat, 1);
    finish_result("max");
  endtask

  task automatic test_settle_stable();
    sel = 1'b1;
    send_txn(16'h1234, 16'h4321, 1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (add_a !== 16'h1234 || add_b !== 16'h4321 || add_cin !== 1'b1 ||
          res_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL settle_stable cyc=%0d got a=%04h b=%04h c=%0b vld=%0b busy=%0b rdy=%0b want 1234/4321/1/0/1/0",
                 i, add_a, add_b, add_cin, res_valid, busy, in_ready);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (res_valid !== 1'b1 || res_sum !== 17'h05556) begin
      errors++;
      $display("FAIL settle_result got vld=%0b sum=%05h want 1/05556", res_valid, res_sum);
    end
    $display("txn settle_stable sum=%05h", res_sum);
    finish_result("settle_stable");
  endtask

  task automatic test_backpressure();
    int lat;
    sel = 1'b0;
    send_txn(16'h0102, 16'h0304, 1'b0, 1'b1, 0);
    wait_result(lat);
    check_sum("backpressure", 17'h00406, lat, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (res_valid !== 1'b1 || res_sum !== 17'h00406 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold cyc=%0d got vld=%0b sum=%05h rdy=%0b busy=%0b want 1/00406/0/1",
                 i, res_valid, res_sum, in_ready, busy);
      end
    end
    finish_result("backpressure");
  endtask

  task automatic test_sof_resync();
    int lat;
    sel = 1'b0;
    send_byte(8'h11, 1'b1, 1'b0, 0);
    send_byte(8'h22, 1'b0, 1'b0, 0);
    send_txn(16'h1234, 16'h4321, 1'b0, 1'b1, 0);
    wait_result(lat);
    check_sum("sof_resync", 17'h05555, lat, 1);
    finish_result("sof_resync");
  endtask

  task automatic test_reset_in_settle();
    int lat;
    sel = 1'b1;
    send_txn(16'h00AA, 16'h0055, 1'b0, 1'b1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready_low got %0b want 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (add_a !== 16'd0 || add_b !== 16'd0 || add_cin !== 1'b0 || res_sum !== 17'd0 ||
        res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_settle got a=%04h b=%04h c=%0b s=%05h vld=%0b busy=%0b rdy=%0b want all 0",
               add_a, add_b, add_cin, res_sum, res_valid, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_txn(16'h8000, 16'h8000, 1'b1, 1'b0, 0);
    wait_result(lat);
    check_sum("after_reset", 17'h10001, lat, 3);
    finish_result("after_reset");
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] a, b;
    logic c;
    logic [16:0] exp;
    sel = 1'b1;
    for (int t = 0; t < 100; t++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom_range(0, 1));
      exp = {1'b0, a} + {1'b0, b} + {16'd0, c};
      send_txn(a, b, c, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      wait_result(lat);
      check_sum($sformatf("b2b_%0d", t), exp, lat, 3);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      finish_result($sformatf("b2b_%0d", t));
    end
  endtask

  initial begin
    test_reset();
    test_carry_out();
    test_settle_stable();
    test_backpressure();
    test_sof_resync();
    test_reset_in_settle();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
